// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mips_pkg                                                        |
// | Purpose  : Shared MIPS decode definitions: opcode / funct codes, ALU class |
// |            encodings, the control bundle carried through ID/EX, and small  |
// |            decode helper functions.                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mips_pkg;

  // Primary opcodes (Instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (Instruction[5:0]); resolved in EX from the
  // sign-extended immediate field when ALUOp selects the funct class.
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation classes handed to EX
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Main control decode. j and unknown opcodes fall through to NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OR;
      end
      OP_SLTI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_SLT;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  // Rs is a real source for every decoded instruction except j / NOP.
  function automatic logic uses_rs(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: uses_rs = 1'b1;
      default:                           uses_rs = 1'b0;
    endcase
  endfunction

  // Rt is a source only where it is read rather than written.
  function automatic logic uses_rt(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: uses_rt = 1'b1;
      default:                         uses_rt = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : register_file                                                   |
// | Purpose  : 32 x DATA_W register file, two asynchronous read ports, one     |
// |            rising-edge write port. $0 always reads zero and ignores writes.|
// | Ports    : clk, reset (async, active-high, clears all registers)           |
// |            raddr1/raddr2 -> rdata1/rdata2 (combinational)                  |
// |            we, waddr, wdata (written on rising clk)                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module register_file #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // $0 is forced to zero on read so the stored entry never matters.
  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_decode                                              |
// | Purpose  : ID stage of a 5-stage MIPS pipeline. Reads the register file,   |
// |            decodes control, resolves beq/bne, detects load-use and branch  |
// |            operand hazards, and owns the ID/EX pipeline register, which    |
// |            updates on the falling clock edge.                              |
// | Ports    : clk, reset (async, active-high)                                 |
// |            Instruction/PCNext          IF/ID word                          |
// |            *_EX / *_MEM inputs         downstream hazard information       |
// |            RegWrite_WB/WriteReg_WB/WriteData_WB  register write-back       |
// |            writeIFID, PCSrc, PCJump    feedback to fetch                   |
// |            *_EX outputs                ID/EX register contents             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instruction_decode
  import mips_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instruction,
  input  logic [PC_W-1:0]   PCNext,
  input  logic              RegWrite_EX,
  input  logic              MemRead_EX,
  input  logic [4:0]        WriteReg_EX,
  input  logic              MemRead_MEM,
  input  logic [4:0]        WriteReg_MEM,
  input  logic              RegWrite_WB,
  input  logic [4:0]        WriteReg_WB,
  input  logic [DATA_W-1:0] WriteData_WB,
  output logic              writeIFID,
  output logic              PCSrc,
  output logic [PC_W-1:0]   PCJump,
  output logic [DATA_W-1:0] ReadData1_EX,
  output logic [DATA_W-1:0] ReadData2_EX,
  output logic [DATA_W-1:0] SignExt_EX,
  output logic [4:0]        Rs_EX,
  output logic [4:0]        Rt_EX,
  output logic [4:0]        Rd_EX,
  output logic [PC_W-1:0]   PCNext_EX,
  output logic              RegDst_EX,
  output logic              ALUSrc_EX,
  output logic              MemRead_EX_o,
  output logic              MemWrite_EX,
  output logic              MemtoReg_EX,
  output logic              RegWrite_EX_o,
  output logic [2:0]        ALUOp_EX
);

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign imm    = Instruction[15:0];

  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  register_file #(
    .DATA_W (DATA_W)
  ) u_register_file (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (read_data1),
    .rdata2 (read_data2),
    .we     (RegWrite_WB),
    .waddr  (WriteReg_WB),
    .wdata  (WriteData_WB)
  );

  // Set for one cycle after a taken branch: the held IF/ID word is the
  // branch itself seen a second time and must be discarded.
  logic squash_q;

  ctrl_t ctrl;
  logic  is_beq;
  logic  is_bne;
  logic  is_branch;
  logic  src_rs;
  logic  src_rt;
  logic  zero_ext;

  assign ctrl      = decode_ctrl(opcode);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_branch = is_beq | is_bne;
  assign src_rs    = uses_rs(opcode);
  assign src_rt    = uses_rt(opcode);
  assign zero_ext  = (opcode == OP_ANDI) | (opcode == OP_ORI);

  logic [DATA_W-1:0] ext_imm;
  assign ext_imm = zero_ext ? {{(DATA_W-16){1'b0}}, imm}
                            : {{(DATA_W-16){imm[15]}}, imm};

  // Hazard detection. Branches compare operands in ID, so any producer still
  // in EX (ALU result) or MEM (load data) must be waited out.
  logic ex_dest_valid;
  logic mem_dest_valid;
  logic ex_match_used;
  logic ex_match_any;
  logic mem_match_any;
  logic load_use;
  logic branch_hazard;
  logic stall;

  assign ex_dest_valid  = (WriteReg_EX != 5'd0);
  assign mem_dest_valid = (WriteReg_MEM != 5'd0);
  assign ex_match_used  = (src_rs & (rs == WriteReg_EX)) | (src_rt & (rt == WriteReg_EX));
  assign ex_match_any   = (rs == WriteReg_EX) | (rt == WriteReg_EX);
  assign mem_match_any  = (rs == WriteReg_MEM) | (rt == WriteReg_MEM);

  assign load_use      = MemRead_EX & ex_dest_valid & ex_match_used;
  assign branch_hazard = is_branch &
                         ((RegWrite_EX & ex_dest_valid & ex_match_any) |
                          (MemRead_MEM & mem_dest_valid & mem_match_any));

  // A squashed word is a NOP and cannot create a hazard.
  assign stall = ~reset & ~squash_q & (load_use | branch_hazard);

  logic taken;
  assign taken = (is_beq & (read_data1 == read_data2)) |
                 (is_bne & (read_data1 != read_data2));

  assign writeIFID = ~stall;
  assign PCSrc     = taken & ~stall & ~squash_q & ~reset;
  assign PCJump    = PCNext + imm[PC_W-1:0];

  // Squashed words, stalls and branches all turn into a bubble.
  logic load_bubble;
  assign load_bubble = squash_q | stall | is_branch;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      squash_q      <= 1'b0;
      ReadData1_EX  <= '0;
      ReadData2_EX  <= '0;
      SignExt_EX    <= '0;
      Rs_EX         <= '0;
      Rt_EX         <= '0;
      Rd_EX         <= '0;
      PCNext_EX     <= '0;
      RegDst_EX     <= 1'b0;
      ALUSrc_EX     <= 1'b0;
      MemRead_EX_o  <= 1'b0;
      MemWrite_EX   <= 1'b0;
      MemtoReg_EX   <= 1'b0;
      RegWrite_EX_o <= 1'b0;
      ALUOp_EX      <= '0;
    end else begin
      squash_q <= PCSrc;
      if (load_bubble) begin
        ReadData1_EX  <= '0;
        ReadData2_EX  <= '0;
        SignExt_EX    <= '0;
        Rs_EX         <= '0;
        Rt_EX         <= '0;
        Rd_EX         <= '0;
        PCNext_EX     <= '0;
        RegDst_EX     <= 1'b0;
        ALUSrc_EX     <= 1'b0;
        MemRead_EX_o  <= 1'b0;
        MemWrite_EX   <= 1'b0;
        MemtoReg_EX   <= 1'b0;
        RegWrite_EX_o <= 1'b0;
        ALUOp_EX      <= '0;
      end else begin
        ReadData1_EX  <= read_data1;
        ReadData2_EX  <= read_data2;
        SignExt_EX    <= ext_imm;
        Rs_EX         <= rs;
        Rt_EX         <= rt;
        Rd_EX         <= rd;
        PCNext_EX     <= PCNext;
        RegDst_EX     <= ctrl.reg_dst;
        ALUSrc_EX     <= ctrl.alu_src;
        MemRead_EX_o  <= ctrl.mem_read;
        MemWrite_EX   <= ctrl.mem_write;
        MemtoReg_EX   <= ctrl.mem_to_reg;
        RegWrite_EX_o <= ctrl.reg_write;
        ALUOp_EX      <= ctrl.alu_op;
      end
    end
  end

endmodule
`default_nettype wire
